// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit seven-segment scan driver.
// All segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low digit enables: an[0] = ones, an[1] = tens.
    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

    localparam int DEF_REFRESH_DIV = 50000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit to active-low seven-segment pattern.
// Codes above 9 render as a blank digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 2-digit common-anode display driver for a 0-15 value.
// The value is captured once per scan frame so a frame never mixes two values.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] val_in,
    output logic [6:0]        seg,
    output logic [1:0]        an,
    output logic              frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic              digit_sel_q, digit_sel_d;
    logic [DATA_W-1:0] latched_q, latched_d;
    logic [6:0]        seg_q, seg_d;
    logic [1:0]        an_q, an_d;
    logic              tick_q, tick_d;

    logic              wrap, boundary;
    logic              ge10;
    logic [3:0]        ones, digit;
    logic [6:0]        dec_seg;

    assign wrap     = (div_cnt_q == CNT_MAX);
    assign boundary = wrap && digit_sel_q;

    // Binary-to-BCD for 0..15 reduces to one compare and one subtract.
    assign ge10 = (latched_q >= DATA_W'(10));
    assign ones = ge10 ? 4'(latched_q - DATA_W'(10)) : 4'(latched_q);
    assign digit = digit_sel_q ? {3'b000, ge10} : ones;

    seg7_decode u_decode (
        .digit_i (digit),
        .seg_o   (dec_seg)
    );

    always_comb begin
        div_cnt_d   = wrap ? '0 : div_cnt_q + 1'b1;
        digit_sel_d = wrap ? ~digit_sel_q : digit_sel_q;
        latched_d   = boundary ? val_in : latched_q;
        tick_d      = boundary;
        an_d        = AN_ONES;
        seg_d       = dec_seg;
        if (digit_sel_q) begin
            // Leading-zero blanking: tens slot is dark for values below 10.
            if (ge10) begin
                an_d = AN_TENS;
            end else begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q   <= '0;
            digit_sel_q <= 1'b0;
            latched_q   <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= AN_OFF;
            tick_q      <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_sel_q <= digit_sel_d;
            latched_q   <= latched_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            tick_q      <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a cycle-count
// based model of what each digit slot should show.
module tb_seg7_scan_driver;

    localparam int R = 4;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] val_in = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int m   = 0;   // edges since reset release
    int lat = 0;   // value shown in the current frame
    int cnt = 0;

    logic [6:0] pat [10];

    seg7_scan_driver #(.DATA_W(4), .REFRESH_DIV(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .val_in     (val_in),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: derive the expected display from which slot of which frame
    // the edge falls in, then compare on the following falling edge.
    task automatic step();
        int         slot;
        logic [6:0] es;
        logic [1:0] ea;
        logic       et;
        @(posedge clk);
        slot = (m / R) % 2;
        if (slot == 0) begin
            ea = 2'b10;
            es = pat[lat % 10];
        end else if (lat >= 10) begin
            ea = 2'b01;
            es = pat[lat / 10];
        end else begin
            ea = 2'b11;
            es = 7'h7F;
        end
        m++;
        et = (m % (2 * R) == 0);
        if (et) lat = int'(val_in);
        @(negedge clk);
        chk("seg", 32'(seg), 32'(es));
        chk("an", 32'(an), 32'(ea));
        chk("frame_tick", 32'(frame_tick), 32'(et));
        chk("an_legal", 32'(an == 2'b00), 32'd0);
    endtask

    task automatic run_frame(input int v);
        val_in = 4'(v);
        do step(); while (m % (2 * R) != 0);
    endtask

    initial begin
        pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

        // Reset with the clock stopped
        #2 reset = 1'b0;
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'h3);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        #2 reset = 1'b1;
        m = 0; lat = 0;
        clk_en = 1'b1;

        // Held values, including a tens digit
        run_frame(7);
        run_frame(7);
        run_frame(13);
        run_frame(13);

        // Mid-frame change is ignored until the next boundary
        run_frame(5);
        repeat (3) step();
        val_in = 4'd12;
        do step(); while (m % (2 * R) != 0);
        run_frame(12);

        // Asynchronous reset in the middle of the tens slot
        val_in = 4'd15;
        do step(); while (!(((m / R) % 2 == 1) && (m % R == 2)));
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_an", 32'(an), 32'h3);
        chk("mid_rst_tick", 32'(frame_tick), 32'h0);
        #1 reset = 1'b1;
        m = 0; lat = 0;
        run_frame(15);
        run_frame(15);

        // Counter advancing once per frame, wrapping 15 -> 0
        cnt = 0;
        for (int f = 0; f < 17; f++) begin
            run_frame(cnt);
            cnt = (cnt + 1) % 16;
        end

        // Random values with random mid-frame changes
        for (int i = 0; i < 40 * R; i++) begin
            if ($urandom_range(0, 3) == 0) val_in = 4'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage for the 4-bit binary counter (counter_n). It converts the 4-bit count (0-15) into two decimal digits and drives a time-multiplexed 2-digit common-anode seven-segment display. A programmable prescaler sets the per-digit dwell time. The input is captured once per scan frame so a digit can never tear mid-frame.

Parameters:
DATA_W, 4, width of val_in; fixed at 4 in this revision, so the value range is 0-15.
REFRESH_DIV, 50000, clock cycles each digit stays lit; must be >= 1; benches use 4.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
val_in  input  DATA_W  binary value to display, normally counter_n out.
seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
an  output  2  digit enables, active-low; an[0] = ones digit, an[1] = tens digit.
frame_tick  output  1  one-cycle pulse marking the start of a new scan frame.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - Outputs: seg=7'h7F, an=2'b11, frame_tick=0.
  - Internal state: div_cnt=0, digit_sel=0, latched=0.
- Prescaler: div_cnt counts 0..REFRESH_DIV-1 and wraps. Its width is clog2(REFRESH_DIV), minimum 1.
  - On the wrap edge, digit_sel toggles.
  - REFRESH_DIV=1 toggles digit_sel every cycle.
- Frame boundary: the edge where div_cnt==REFRESH_DIV-1 and digit_sel==1.
  - latched <= val_in.
  - digit_sel <= 0.
  - frame_tick <= 1, for exactly one cycle; cleared on every other edge.
  - Frame length is 2*REFRESH_DIV cycles.
- Between boundaries, val_in is ignored, including any mid-frame changes.
- Digit split:
  - ones = latched mod 10.
  - tens = latched / 10 (0 or 1).
  - Implement as a compare against 10 plus a subtract. No divider.
- Output registers: seg and an are registered every edge from the pre-edge digit_sel and latched values. Outputs therefore lag state by 1 cycle.
  - First edge after reset release: an=2'b10, seg = pattern for 0 (7'h40).
  - The new latched value appears on seg 1 cycle after frame_tick rises.
- digit_sel=0 (ones slot): an=2'b10, seg = pattern(ones).
- digit_sel=1 (tens slot):
  - If latched >= 10: an=2'b01, seg = pattern(1) = 7'h79.
  - If latched < 10: leading-zero blanking, an=2'b11, seg=7'h7F.
- Segment patterns, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19.
  - 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any other code gives 7F.
- Only one an bit may ever be low. an=2'b00 is illegal; the bench asserts against it.
- Reset asserted mid-frame: immediate clear. Scanning restarts at the ones slot with latched=0. The first frame_tick after release comes after 2*REFRESH_DIV edges.
- Simultaneous val_in change and frame boundary on the same edge: the value present at that edge is captured.

Decomposition:
- Package seg7_pkg:
  - 7-bit segment constants SEG_0..SEG_9.
  - SEG_BLANK=7'h7F.
  - AN_OFF=2'b11.
  - Default REFRESH_DIV.
- Sub-module seg7_decode: combinational 4-bit digit to 7-bit active-low pattern. Out-of-range codes give SEG_BLANK.
- seg7_scan_driver owns the prescaler, digit_sel, the latch, the digit split and the output registers.

Test Plan:
1. reset=0 with clk stopped -> seg=7F, an=11, frame_tick=0 immediately. Release, then first edge -> an=10, seg=40.
2. REFRESH_DIV=4, val_in=7 held -> after frame_tick: ones slot an=10, seg=78 for 4 cycles; tens slot an=11, seg=7F for 4 cycles. frame_tick spacing is exactly 8 cycles.
3. val_in=13 -> ones slot an=10, seg=30; tens slot an=01, seg=79.
4. val_in=5 latched, then changed to 12 mid-frame -> seg stays 12 (digit 5) and tens stays blank until the next frame_tick. After it: ones seg=24, tens an=01, seg=79.
5. reset pulsed low for 2 ns mid tens slot while val_in=15 -> outputs clear asynchronously to 7F/11. After release: an=10, seg=40; the next frame latches 15, giving ones seg=12, tens seg=79.
6. counter_n driving val_in with counter_n advancing once per frame; run 16 frames -> each frame shows the expected pair for 0..15 and wraps 15->0. an never equals 00.
